axi_sram_slave: RTL

- AXI4 responder backed by a synchronous on-chip SRAM array.
- It is the far end of the 6-bit-ID memory master port that the SoC exposes from its memory mux.
- Used as a boot/scratch RAM for ASIC builds and as the memory model in SoC-level simulation.
- Handles one transaction at a time, read or write, with FIXED/INCR/WRAP bursts up to 256 beats.

---
 rtl/axi_sram_pkg.sv | 31 +++
 rtl/axi_sram_slave_addr_gen.sv | 39 +++
 rtl/axi_sram_slave.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: burst/response encodings, FSM states and the
// WRAP window helpers shared by the AXI SRAM slave.
package axi_sram_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_DATA
  } state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [31:0] wrap_mask(
    input logic [7:0] len,
    input logic [1:0] size
  );
    return ((32'(len) + 32'd1) << size) - 32'd1;
  endfunction

endpackage

// File: rtl/axi_sram_slave_addr_gen.sv
// axi_burst_addr_gen: next beat address and beat count for
// FIXED/INCR/WRAP bursts, shared by the read and write paths.
module axi_burst_addr_gen
  import axi_sram_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_burst,
  input  logic [7:0]  i_beat,
  output logic [31:0] o_next_addr,
  output logic [7:0]  o_next_beat,
  output logic        o_last
);

  logic [1:0]  w_size;
  logic [31:0] w_sum;
  logic [31:0] w_mask;

  assign w_size      = (i_size > 3'd2) ? 2'd2 : i_size[1:0];
  assign w_sum       = i_addr + (32'd1 << w_size);
  assign w_mask      = wrap_mask(i_len, w_size);
  assign o_next_beat = i_beat + 8'd1;
  assign o_last      = (i_beat == i_len);

  // Illegal WRAP lengths and the reserved burst code fall back to INCR
  always_comb begin
    o_next_addr = w_sum;
    unique case (1'b1)
      (i_burst == FIXED):
        o_next_addr = i_addr;
      (i_burst == WRAP) && wrap_len_ok(i_len):
        o_next_addr = (i_addr & ~w_mask) | (w_sum & w_mask);
      default:
        o_next_addr = w_sum;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder over an on-chip SRAM, one burst at a time.
// Define AXI_SRAM_SLVERR_EN to answer out-of-window beats with SLVERR.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int          ID_WIDTH    = 6,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_WIDTH-1:0] s_awid,
  input  logic [31:0]         s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_WIDTH-1:0] s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_WIDTH-1:0] s_arid,
  input  logic [31:0]         s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_WIDTH-1:0] s_rid,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t              r_state;
  logic                r_last_wr;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_addr;
  logic [7:0]          r_len;
  logic [7:0]          r_beat;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [1:0]          r_bresp;
  logic [1:0]          r_rresp;
  logic                r_rvalid;
  logic                r_rlast;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_grant_rd;
  logic          w_grant_wr;
  logic          w_wr_hs;
  logic          w_rd_hs;
  logic          w_last;
  logic          w_oor;
  logic          w_unused;
  logic [7:0]    w_next_beat;
  logic [31:0]   w_next_addr;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_off;
  logic [31:0]   w_rd_word;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_beat_resp;

  axi_burst_addr_gen u_agen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .i_beat      (r_beat),
    .o_next_addr (w_next_addr),
    .o_next_beat (w_next_beat),
    .o_last      (w_last)
  );

  // On a tie the channel not served last wins
  assign w_idle     = aresetn && (r_state == IDLE);
  assign w_grant_rd = s_arvalid && (!s_awvalid || r_last_wr);
  assign w_grant_wr = s_awvalid && (!s_arvalid || !r_last_wr);
  assign s_arready  = w_idle && w_grant_rd;
  assign s_awready  = w_idle && w_grant_wr;
  assign s_wready   = aresetn && (r_state == WR_DATA);
  assign s_bvalid   = aresetn && (r_state == WR_RESP);
  assign s_bid      = r_id;
  assign s_bresp    = r_bresp;
  assign s_rid      = r_id;
  assign s_rdata    = r_rdata;
  assign s_rresp    = r_rresp;
  assign s_rlast    = r_rlast;
  assign s_rvalid   = r_rvalid;

  assign w_wr_hs    = s_wready && s_wvalid;
  assign w_rd_hs    = r_rvalid && s_rready;
  // Prefetch the following beat as soon as the current one is taken
  assign w_acc_addr = w_rd_hs ? w_next_addr : r_addr;
  assign w_off      = w_acc_addr - BASE_ADDR;
  assign w_idx      = w_off[2 +: AW];

`ifdef AXI_SRAM_SLVERR_EN
  assign w_oor    = |w_off[31:AW+2];
  assign w_unused = ^{w_off[1:0], s_wlast};
`else
  assign w_oor    = 1'b0;
  assign w_unused = ^{w_off[31:AW+2], w_off[1:0], s_wlast};
`endif

  assign w_beat_resp = w_oor ? SLVERR : OKAY;
  assign w_rd_word   = w_oor ? 32'h0 : r_mem[w_idx];

  always_ff @(posedge aclk) begin
    if (aresetn && w_wr_hs && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) r_mem[w_idx][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_last_wr <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_bresp   <= OKAY;
      r_rresp   <= OKAY;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s_arready) begin
            r_id      <= s_arid;
            r_addr    <= s_araddr;
            r_len     <= s_arlen;
            r_size    <= s_arsize;
            r_burst   <= s_arburst;
            r_beat    <= '0;
            r_last_wr <= 1'b0;
            r_state   <= RD_DATA;
          end else if (s_awready) begin
            r_id      <= s_awid;
            r_addr    <= s_awaddr;
            r_len     <= s_awlen;
            r_size    <= s_awsize;
            r_burst   <= s_awburst;
            r_beat    <= '0;
            r_bresp   <= OKAY;
            r_last_wr <= 1'b1;
            r_state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_wr_hs) begin
            r_bresp <= r_bresp | w_beat_resp;
            r_addr  <= w_next_addr;
            r_beat  <= w_next_beat;
            if (w_last) r_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_bready) r_state <= IDLE;
        end
        RD_DATA: begin
          if (w_rd_hs && w_last) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_state  <= IDLE;
          end else if (!r_rvalid || s_rready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
            r_rresp  <= w_beat_resp;
            if (r_rvalid) begin
              r_addr  <= w_next_addr;
              r_beat  <= w_next_beat;
              r_rlast <= (w_next_beat == r_len);
            end else begin
              r_rlast <= w_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
